apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB4 initiator: turns single-beat requests (valid/ready) into APB SETUP/ACCESS transfers
//  to SLV_CNT one-hot-selected responders (UART IP register blocks).
//  Returns rdata/error on a held response channel and aborts stalled transfers by timeout.
//  Used as the RTL APB master in system-level sims and the CPU-side bus bridge.
// PARAMETERS
//  APB_AW   32  address width
//  DW       32  data width; pstrb width = DW/8
//  SLV_CNT  4   responders; power of 2, >=2; psel/pready/pslverr/prdata are per-slave arrays
//  SEL_LSB  12  slave index = req_addr[SEL_LSB +: $clog2(SLV_CNT)]
//  TIMEOUT  16  max ACCESS cycles without pready before abort; 0 = timeout disabled
// PORTS
//  pclk         in   1              clock, all logic on posedge
//  preset       in   1              one clock; reset is synchronous and active-high
//  req_valid    in   1              request present
//  req_ready    out  1              request accepted when valid&ready
//  req_write    in   1              1=write, 0=read
//  req_addr     in   APB_AW         byte address
//  req_wdata    in   DW             write data
//  req_strb     in   DW/8           write byte strobes
//  req_prot     in   3              pprot value
//  rsp_valid    out  1              response present, held until rsp_ready
//  rsp_ready    in   1              response consumed
//  rsp_rdata    out  DW             read data (0 for writes and timeouts)
//  rsp_err      out  1              pslverr or timeout
//  rsp_timeout  out  1              transfer aborted by timeout
//  psel         out  SLV_CNT        one-hot select
//  penable      out  1              ACCESS phase
//  pwrite/paddr/pwdata/pstrb/pprot out 1/APB_AW/DW/DW/8/3  APB request fields
//  prdata       in   SLV_CNT x DW   per-slave read data
//  pready       in   SLV_CNT        per-slave ready
//  pslverr      in   SLV_CNT        per-slave error
// BEHAVIOUR
//  All outputs registered. Reset: state=IDLE; psel, penable, pwrite, paddr, pwdata, pstrb,
//  pprot, rsp_* and timer = 0. req_ready=0 while preset=1.
//  Reset mid-transfer: bus returns to idle on the next edge, no response issued.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE:
//   IDLE  : req_ready=1. On valid&ready: latch fields, idx, go SETUP.
//           Read forces pstrb=0.
//   SETUP : psel[idx]=1, penable=0; always -> ACCESS next cycle.
//   ACCESS: psel[idx]=1, penable=1, timer++ each cycle.
//           pready[idx]=1: capture prdata[idx] (reads only), rsp_err=pslverr[idx] -> RESP.
//           Else if TIMEOUT!=0 and timer==TIMEOUT-1: rsp_err=1, rsp_timeout=1 -> RESP (abort).
//           pready takes priority over timeout in the same cycle.
//   RESP  : psel=0, penable=0, rsp_valid=1, fields held stable; on rsp_ready -> IDLE.
//  Latency: req handshake edge n -> SETUP n+1 -> ACCESS n+2 -> rsp_valid n+3 with zero waits;
//   +1 cycle per wait state. Throughput: one transfer per 4 cycles minimum.
//  paddr/pwdata/pwrite/pstrb/pprot stable from SETUP through end of ACCESS; they keep their
//   last value afterwards. psel never has more than one bit set.
//  Inputs of non-selected slaves are ignored. Timer clears on entry to SETUP.
//  A timeout abort drops penable without pready. This intentionally violates the
//   completion-with-pready assertion; benches disable it or expect it on timeout tests.
// TESTING
//  1 write 0x0000_1004 (slave 1) data 0xA5A5_0001 strb 0xF, pready tied 1
//    -> psel=4'b0010 at n+1, penable at n+2, rsp_valid at n+3, rsp_err=0.
//  2 read 0x0000_3008 (slave 3), pready low 3 cycles, prdata[3]=0xDEAD_BEEF
//    -> penable 4 cycles, rsp_rdata=0xDEAD_BEEF, pstrb=0 throughout.
//  3 read with pslverr[2]=1 at pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEAD_BEEF.
//  4 TIMEOUT=16, pready never set -> 16 ACCESS cycles, then abort: rsp_err=1, rsp_timeout=1.
//  5 rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0; on release -> IDLE.
//  6 preset=1 during ACCESS -> next edge psel=0, penable=0, paddr=0, no rsp_valid;
//    req accepted after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB4 initiator: turns single-beat valid/ready requests into SETUP/ACCESS transfers
// to one-hot selected responders, with a held response channel and an ACCESS-phase timeout.
module apb_master_bridge #(
  parameter int APB_AW  = 32,
  parameter int DW      = 32,
  parameter int SLV_CNT = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [APB_AW-1:0]             req_addr,
  input  logic [DW-1:0]                 req_wdata,
  input  logic [DW/8-1:0]               req_strb,
  input  logic [2:0]                    req_prot,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DW-1:0]                 rsp_rdata,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic [SLV_CNT-1:0]            psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [APB_AW-1:0]             paddr,
  output logic [DW-1:0]                 pwdata,
  output logic [DW/8-1:0]               pstrb,
  output logic [2:0]                    pprot,
  input  logic [SLV_CNT-1:0][DW-1:0]    prdata,
  input  logic [SLV_CNT-1:0]            pready,
  input  logic [SLV_CNT-1:0]            pslverr
);

  localparam int SW = DW / 8;
  localparam int IW = (SLV_CNT > 1) ? $clog2(SLV_CNT) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [IW-1:0]       req_idx;
  logic                handshake;
  logic                sel_ready, sel_err, timeout_hit;
  logic [DW-1:0]       sel_rdata;

  logic                req_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DW-1:0]       rsp_rdata_d, pwdata_d;
  logic [SLV_CNT-1:0]  psel_d;
  logic                penable_d, pwrite_d;
  logic [APB_AW-1:0]   paddr_d;
  logic [SW-1:0]       pstrb_d;
  logic [2:0]          pprot_d;

  assign req_idx     = req_addr[SEL_LSB +: IW];
  assign handshake   = req_valid && req_ready;
  assign sel_ready   = pready[idx_q];
  assign sel_err     = pslverr[idx_q];
  assign sel_rdata   = prdata[idx_q];
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMAX);

  always_ff @(posedge pclk) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output; request fields hold once latched.
  always_comb begin
    idx_d         = idx_q;
    timer_d       = timer_q;
    req_ready_d   = (state_d == IDLE);
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    pstrb_d       = pstrb;
    pprot_d       = pprot;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          idx_d     = req_idx;
          timer_d   = '0;
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_wdata;
          pstrb_d   = req_write ? req_strb : '0;
          pprot_d   = req_prot;
          psel_d    = SLV_CNT'(1) << req_idx;
          penable_d = 1'b0;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        timer_d = timer_q + 1'b1;
        // A responder completing in the last allowed cycle wins over the abort.
        if (sel_ready) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = sel_err;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end
      end
      RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      idx_q       <= '0;
      timer_q     <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      psel        <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
    end else begin
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      pstrb       <= pstrb_d;
      pprot       <= pprot_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: bench drives the responder side directly
// and compares every observed field against hand-computed values.
module tb_apb_master_bridge;

  logic              pclk = 1'b0;
  logic              preset;
  logic              req_valid, req_ready, req_write;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_strb;
  logic [2:0]        req_prot;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]       rsp_rdata;
  logic [3:0]        psel;
  logic              penable, pwrite;
  logic [31:0]       paddr, pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [3:0][31:0]  prdata;
  logic [3:0]        pready, pslverr;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cnt;

  apb_master_bridge #(
    .APB_AW(32), .DW(32), .SLV_CNT(4), .SEL_LSB(12), .TIMEOUT(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the bridge idle; returns one negedge after the handshake edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [2:0] prot);
    checkOutput("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    req_prot  = prot;
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    preset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    rsp_ready = 1'b1;
    prdata    = '0;
    pready    = '0;
    pslverr   = '0;

    repeat (2) @(negedge pclk);
    checkOutput("rst_psel", {60'd0, psel}, 64'd0);
    checkOutput("rst_penable", {63'd0, penable}, 64'd0);
    checkOutput("rst_paddr", {32'd0, paddr}, 64'd0);
    checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd0);
    preset = 1'b0;
    @(negedge pclk);

    $display("[TB] test 1: zero-wait write to slave 1");
    pready = 4'hF;
    applyStimulus(1'b1, 32'h0000_1004, 32'hA5A5_0001, 4'hF, 3'b010);
    checkOutput("t1_setup_psel", {60'd0, psel}, 64'h2);
    checkOutput("t1_setup_penable", {63'd0, penable}, 64'd0);
    checkOutput("t1_paddr", {32'd0, paddr}, 64'h0000_1004);
    checkOutput("t1_pwdata", {32'd0, pwdata}, 64'hA5A5_0001);
    checkOutput("t1_pstrb", {60'd0, pstrb}, 64'hF);
    checkOutput("t1_pwrite", {63'd0, pwrite}, 64'd1);
    checkOutput("t1_pprot", {61'd0, pprot}, 64'd2);
    @(negedge pclk);
    checkOutput("t1_access_penable", {63'd0, penable}, 64'd1);
    checkOutput("t1_access_psel", {60'd0, psel}, 64'h2);
    @(negedge pclk);
    checkOutput("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("t1_rsp_err", {63'd0, rsp_err}, 64'd0);
    checkOutput("t1_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    checkOutput("t1_resp_psel", {60'd0, psel}, 64'd0);
    checkOutput("t1_resp_penable", {63'd0, penable}, 64'd0);
    @(negedge pclk);
    checkOutput("t1_idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);

    $display("[TB] test 2: read slave 3 with three wait states");
    pready    = 4'b0001;
    prdata[0] = 32'h1111_1111;
    prdata[3] = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 32'h0000_3008, 32'hFFFF_FFFF, 4'hF, 3'b000);
    checkOutput("t2_setup_psel", {60'd0, psel}, 64'h8);
    checkOutput("t2_setup_pstrb", {60'd0, pstrb}, 64'd0);
    checkOutput("t2_pwrite", {63'd0, pwrite}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      checkOutput("t2_access_penable", {63'd0, penable}, 64'd1);
      checkOutput("t2_access_pstrb", {60'd0, pstrb}, 64'd0);
      if (i == 3) pready = 4'b1001;
    end
    @(negedge pclk);
    pready = '0;
    checkOutput("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("t2_rsp_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
    checkOutput("t2_rsp_err", {63'd0, rsp_err}, 64'd0);
    @(negedge pclk);

    $display("[TB] test 3: read slave 2 with slave error");
    prdata[2] = 32'hDEAD_BEEF;
    pready    = 4'b0100;
    pslverr   = 4'b0100;
    applyStimulus(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b001);
    checkOutput("t3_setup_psel", {60'd0, psel}, 64'h4);
    repeat (2) @(negedge pclk);
    pready  = '0;
    pslverr = '0;
    checkOutput("t3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("t3_rsp_err", {63'd0, rsp_err}, 64'd1);
    checkOutput("t3_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    checkOutput("t3_rsp_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
    @(negedge pclk);

    $display("[TB] test 4: timeout abort on slave 0");
    prdata[0] = 32'h0BAD_F00D;
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000);
    checkOutput("t4_setup_psel", {60'd0, psel}, 64'h1);
    cnt = 0;
    @(negedge pclk);
    while (penable === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge pclk);
    end
    checkOutput("t4_access_cycles", 64'(cnt), 64'd16);
    checkOutput("t4_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("t4_rsp_err", {63'd0, rsp_err}, 64'd1);
    checkOutput("t4_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
    checkOutput("t4_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    checkOutput("t4_resp_psel", {60'd0, psel}, 64'd0);
    @(negedge pclk);

    $display("[TB] test 5: response back-pressure");
    rsp_ready = 1'b0;
    pready    = 4'b0010;
    prdata[1] = 32'h1234_5678;
    applyStimulus(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000);
    repeat (2) @(negedge pclk);
    pready    = '0;
    prdata[1] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("t5_hold_rsp_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
      checkOutput("t5_hold_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge pclk);
    end
    checkOutput("t5_still_valid", {63'd0, rsp_valid}, 64'd1);
    rsp_ready = 1'b1;
    @(negedge pclk);
    checkOutput("t5_release_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("t5_release_req_ready", {63'd0, req_ready}, 64'd1);

    $display("[TB] test 6: reset during ACCESS");
    applyStimulus(1'b1, 32'h0000_2040, 32'hCAFE_0006, 4'b0011, 3'b000);
    @(negedge pclk);
    checkOutput("t6_access_penable", {63'd0, penable}, 64'd1);
    preset = 1'b1;
    @(negedge pclk);
    checkOutput("t6_rst_psel", {60'd0, psel}, 64'd0);
    checkOutput("t6_rst_penable", {63'd0, penable}, 64'd0);
    checkOutput("t6_rst_paddr", {32'd0, paddr}, 64'd0);
    checkOutput("t6_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("t6_rst_req_ready", {63'd0, req_ready}, 64'd0);
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("t6_post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    pready = 4'hF;
    applyStimulus(1'b1, 32'h0000_2044, 32'h0000_BEEF, 4'hF, 3'b000);
    checkOutput("t6_setup_psel", {60'd0, psel}, 64'h4);
    repeat (2) @(negedge pclk);
    checkOutput("t6_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("t6_rsp_err", {63'd0, rsp_err}, 64'd0);
    @(negedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
